// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit direction counters.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   fetch_pc_i          fetch PC; lookup is combinational, zero latency
//   btb_hit             fetch_pc_i matches a valid entry
//   btb_pre_pc          stored target of the hit entry, 0 on miss
//   predict_taken       counter MSB of the hit entry, 0 on miss
//   execute_valid_i     resolved control transfer present this cycle
//   execute_pc_i        PC of the resolved instruction
//   execute_taken_i     resolved direction (1 = taken)
//   execute_target_i    resolved target address
//   flush_all_i         invalidate every entry; wins over a same-cycle update
//
// Entry layout: valid, tag = pc[31:IDX_W+2], 32-bit target, 2-bit counter
// (00 strong NT, 01 weak NT, 10 weak T, 11 strong T). Index = pc[IDX_W+1:2].
module btb_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc_i,
    output logic        btb_hit,
    output logic [31:0] btb_pre_pc,
    output logic        predict_taken,
    input  logic        execute_valid_i,
    input  logic [31:0] execute_pc_i,
    input  logic        execute_taken_i,
    input  logic [31:0] execute_target_i,
    input  logic        flush_all_i
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // Field extraction
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_en;
    logic             upd_hit;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign fetch_tag = fetch_pc_i[31:IDX_W+2];
    assign upd_idx   = execute_pc_i[IDX_W+1:2];
    assign upd_tag   = execute_pc_i[31:IDX_W+2];

    // Byte-offset bits never participate in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[1:0], execute_pc_i[1:0]};

    // Lookup reads the registered arrays, so a same-cycle update is seen next cycle
    always_comb begin
        btb_hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        btb_pre_pc    = btb_hit ? target_q[fetch_idx] : 32'h0;
        predict_taken = btb_hit && ctr_q[fetch_idx][1];
    end

    // Next-state: flush beats update; update only when valid and out of reset
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_en   = execute_valid_i && rst_n && !flush_all_i;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

        if (flush_all_i) begin
            valid_d = '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                if (execute_taken_i) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                    end
                    target_d[upd_idx] = execute_target_i;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
            end else if (execute_taken_i) begin
                // Allocate or replace; not-taken misses never allocate
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = execute_target_i;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    // Valid bits and counters carry reset state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target arrays are qualified by valid and need no reset
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: expected lookups are queued when
// stimulus is driven and compared when the lookup result is sampled.
module tb_btb_predictor;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc_i;
    logic        btb_hit;
    logic [31:0] btb_pre_pc;
    logic        predict_taken;
    logic        execute_valid_i;
    logic [31:0] execute_pc_i;
    logic        execute_taken_i;
    logic [31:0] execute_target_i;
    logic        flush_all_i;

    always #5 clk = ~clk;

    btb_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_pc_i       (fetch_pc_i),
        .btb_hit          (btb_hit),
        .btb_pre_pc       (btb_pre_pc),
        .predict_taken    (predict_taken),
        .execute_valid_i  (execute_valid_i),
        .execute_pc_i     (execute_pc_i),
        .execute_taken_i  (execute_taken_i),
        .execute_target_i (execute_target_i),
        .flush_all_i      (flush_all_i)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
        logic        tk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push_exp(input logic [31:0] pc, input logic hit,
                            input logic [31:0] tgt, input logic tk);
        exp_t e;
        e.pc = pc; e.hit = hit; e.tgt = tgt; e.tk = tk;
        exp_q.push_back(e);
    endtask

    // Idle execute bus carries junk so valid gating is exercised everywhere
    task automatic idle_execute();
        execute_valid_i  = 1'b0;
        execute_pc_i     = $urandom;
        execute_taken_i  = 1'($urandom_range(1, 0));
        execute_target_i = $urandom;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        @(negedge clk);
        execute_valid_i  = 1'b1;
        execute_pc_i     = pc;
        execute_taken_i  = tk;
        execute_target_i = tgt;
        @(posedge clk);
        #1;
        idle_execute();
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] pcs [3];
        pcs[0] = 32'h8000_0010; pcs[1] = 32'h0000_0000; pcs[2] = 32'hFFFF_FFFC;
        @(negedge clk);
        rst_n = 1'b0; flush_all_i = 1'b0; fetch_pc_i = 32'h8000_0010;
        execute_valid_i = 1'b1; execute_pc_i = 32'h8000_0010;
        execute_taken_i = 1'b1; execute_target_i = 32'h8000_0100;
        @(posedge clk);
        @(negedge clk);
        push_exp(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
            n_fail++;
            $display("FAIL reset_low pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                     e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_execute();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fetch_pc_i = pcs[i];
            push_exp(pcs[i], 1'b0, 32'h0, 1'b0);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL after_reset pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    task automatic test_allocate();
        exp_t e;
        drive_update(32'h8000_0010, 1'b1, 32'h8000_0100);
        push_exp(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b1);
        push_exp(32'h8000_0014, 1'b0, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            fetch_pc_i = exp_q[0].pc;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL allocate pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    // Counter walk from 10: T T NT NT NT NT T T; NT updates carry a junk target
    task automatic test_counter();
        exp_t e;
        logic        tk_seq  [8];
        logic        exp_tk  [8];
        logic [31:0] tgt;
        tk_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_tk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            tgt = tk_seq[i] ? 32'h8000_0108 : 32'hDEAD_BEEF;
            drive_update(32'h8000_0010, tk_seq[i], tgt);
            @(negedge clk);
            fetch_pc_i = 32'h8000_0010;
            push_exp(32'h8000_0010, 1'b1, 32'h8000_0108, exp_tk[i]);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL counter step %0d got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         i, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    task automatic test_alias();
        exp_t e;
        drive_update(32'h8000_0050, 1'b1, 32'h8000_0200);
        drive_update(32'h8000_0090, 1'b0, 32'h8000_0300);
        push_exp(32'h8000_0010, 1'b0, 32'h0, 1'b0);
        push_exp(32'h8000_0050, 1'b1, 32'h8000_0200, 1'b1);
        push_exp(32'h8000_0090, 1'b0, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            fetch_pc_i = exp_q[0].pc;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL alias pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    // Same-cycle lookup sees old contents; new contents appear after the edge
    task automatic test_bypass();
        exp_t e;
        logic [31:0] pcs     [2];
        logic [31:0] new_tgt [2];
        logic        old_hit [2];
        logic [31:0] old_tgt [2];
        pcs[0] = 32'h8000_0050; new_tgt[0] = 32'h8000_0204; old_hit[0] = 1'b1; old_tgt[0] = 32'h8000_0200;
        pcs[1] = 32'h8000_0020; new_tgt[1] = 32'h8000_0500; old_hit[1] = 1'b0; old_tgt[1] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            execute_valid_i = 1'b1; execute_pc_i = pcs[i];
            execute_taken_i = 1'b1; execute_target_i = new_tgt[i];
            fetch_pc_i = pcs[i];
            push_exp(pcs[i], old_hit[i], old_tgt[i], old_hit[i]);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL bypass_old pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
            @(posedge clk);
            #1;
            idle_execute();
            push_exp(pcs[i], 1'b1, new_tgt[i], 1'b1);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL bypass_new pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        @(negedge clk);
        flush_all_i = 1'b1;
        execute_valid_i = 1'b1; execute_pc_i = 32'h8000_0030;
        execute_taken_i = 1'b1; execute_target_i = 32'h8000_0400;
        fetch_pc_i = 32'h8000_0050;
        push_exp(32'h8000_0050, 1'b1, 32'h8000_0204, 1'b1);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
            n_fail++;
            $display("FAIL flush_cycle pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                     e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
        end
        @(posedge clk);
        #1;
        flush_all_i = 1'b0;
        idle_execute();
        push_exp(32'h8000_0050, 1'b0, 32'h0, 1'b0);
        push_exp(32'h8000_0020, 1'b0, 32'h0, 1'b0);
        push_exp(32'h8000_0030, 1'b0, 32'h0, 1'b0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            fetch_pc_i = exp_q[0].pc;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL after_flush pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    // One taken update per cycle with no gaps, then read every entry back
    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] pc;
        logic [31:0] tgt;
        for (int i = 0; i < 4; i++) begin
            pc  = 32'h8000_1000 + 32'(i * 4);
            tgt = 32'h9000_0000 + 32'(i * 16);
            @(negedge clk);
            execute_valid_i = 1'b1; execute_pc_i = pc;
            execute_taken_i = 1'b1; execute_target_i = tgt;
            push_exp(pc, 1'b1, tgt, 1'b1);
        end
        @(posedge clk);
        #1;
        idle_execute();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            fetch_pc_i = exp_q[0].pc;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({btb_hit, btb_pre_pc, predict_taken} !== {e.hit, e.tgt, e.tk}) begin
                n_fail++;
                $display("FAIL back_to_back pc=%h got hit=%b tgt=%h tk=%b want hit=%b tgt=%h tk=%b",
                         e.pc, btb_hit, btb_pre_pc, predict_taken, e.hit, e.tgt, e.tk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush_all_i = 1'b0; fetch_pc_i = 32'h0;
        execute_valid_i = 1'b0; execute_pc_i = 32'h0;
        execute_taken_i = 1'b0; execute_target_i = 32'h0;
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_bypass();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
